pipe_share_arbiter: RTL

PIPE_SHARE_ARBITER -- requirements
Module: pipe_share_arbiter

---
 rtl/pipe_share_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pipe_share_arbiter.sv
// Round-robin arbiter sharing one fixed-latency valid-tagged pipeline among N_REQ requesters.
// Optional tag/valid consistency check enabled by defining PIPE_ARB_CHECK_EN.
module pipe_share_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int MAX_OUTST = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_vld,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_gnt,
    output logic                   pipe_in_vld,
    output logic [WIDTH-1:0]       pipe_in_data,
    input  logic                   pipe_out_vld,
    input  logic [WIDTH-1:0]       pipe_out_data,
    output logic [N_REQ-1:0]       rsp_vld,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   err
);

    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IDW-1:0]   rr_ptr;
    logic [3:0]       outst [N_REQ];
    logic [DEPTH-1:0] tag_vld;
    logic [IDW-1:0]   tag_id [DEPTH];

    logic [N_REQ-1:0] ret;
    logic [N_REQ-1:0] elig;
    logic             gnt_found;
    logic [IDW-1:0]   gnt_idx;
    logic [IDW-1:0]   cand;

    // A slot freed by this cycle's returning response can be reused in the same cycle.
    always_comb begin
        ret  = '0;
        elig = '0;
        for (int k = 0; k < N_REQ; k++) begin
            ret[k]  = tag_vld[DEPTH-1] && (tag_id[DEPTH-1] == IDW'(k));
            elig[k] = !rst && req_vld[k] &&
                      ((outst[k] - {3'b000, ret[k]}) < 4'(MAX_OUTST));
        end
    end

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = IDW'((int'(rr_ptr) + i) % N_REQ);
            if (!gnt_found && elig[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        req_gnt      = '0;
        pipe_in_data = '0;
        if (gnt_found) begin
            req_gnt[gnt_idx] = 1'b1;
            pipe_in_data     = req_data[gnt_idx*WIDTH +: WIDTH];
        end
    end

    assign pipe_in_vld = gnt_found;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (gnt_found) begin
            rr_ptr <= (gnt_idx == IDW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Tag pipeline: stage 0 captures the grant, stage DEPTH-1 aligns with pipe_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld <= '0;
        end else begin
            tag_vld <= {tag_vld[DEPTH-2:0], gnt_found};
        end
    end

    always_ff @(posedge clk) begin
        tag_id[0] <= gnt_idx;
        for (int i = 1; i < DEPTH; i++) begin
            tag_id[i] <= tag_id[i-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < N_REQ; k++) begin
            if (rst) begin
                outst[k] <= '0;
            end else if (req_gnt[k] && !ret[k]) begin
                outst[k] <= outst[k] + 4'd1;
            end else if (!req_gnt[k] && ret[k]) begin
                outst[k] <= outst[k] - 4'd1;
            end
        end
    end

    assign rsp_vld  = rst ? '0 : (ret & {N_REQ{pipe_out_vld}});
    assign rsp_data = (tag_vld[DEPTH-1] && !rst) ? pipe_out_data : '0;

`ifdef PIPE_ARB_CHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (pipe_out_vld != tag_vld[DEPTH-1]) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
